// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller.
// State encoding and the default operand width.
package serial_adder_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_RUN  = RUN,
    S_DONE = DONE
  } state_t;

endpackage

// File: rtl/full_adder.sv
// 1-bit full adder cell.
// Ports: a, b, cin in; sum, carry out.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, LSB first.
// Ports: clk, rst, start, a, b, cin in; busy, done, sum, cout out.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;

  logic             w_fa_sum;
  logic             w_fa_carry;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  full_adder u_fa (
    .a     (r_a_sh[0]),
    .b     (r_b_sh[0]),
    .cin   (r_carry),
    .sum   (w_fa_sum),
    .carry (w_fa_carry)
  );

  // New sum bit enters at the MSB; the result shifts right.
  assign w_res_next = (r_res >> 1)
                    | (WIDTH'(w_fa_sum) << (WIDTH - 1));

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end else begin
          w_next   = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sh  <= r_a_sh >> 1;
      r_b_sh  <= r_b_sh >> 1;
      r_res   <= w_res_next;
      r_carry <= w_fa_carry;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        sum  <= w_res_next;
        cout <= w_fa_carry;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl.
// Covers WIDTH=8 and WIDTH=1 builds.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;

  logic start1, a1, b1, cin1;
  logic busy1, done1, sum1, cout1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) u0 (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done),
    .sum(sum), .cout(cout)
  );

  serial_adder_ctrl #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(start1),
    .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1),
    .sum(sum1), .cout(cout1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on the 8-bit DUT; expected
  // result is supplied by the caller.
  task automatic run8(input logic [7:0] ia,
                      input logic [7:0] ib,
                      input logic       ic,
                      input logic [7:0] es,
                      input logic       ec,
                      input string      nm);
    int n, nb;
    start = 1'b1; a = ia; b = ib; cin = ic;
    step();
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    cin = 1'($urandom);
    n = 0; nb = 0;
    while (!done && n < 40) begin
      chk({nm, " overlap"}, 32'(busy & done), 0);
      if (busy) nb++;
      step();
      n++;
    end
    chk({nm, " latency"}, n, W);
    chk({nm, " busylen"}, nb, W);
    chk({nm, " sum"}, 32'(sum), 32'(es));
    chk({nm, " cout"}, 32'(cout), 32'(ec));
    step();
    chk({nm, " donepulse"}, 32'(done), 0);
    chk({nm, " held"}, 32'({cout, sum}),
        32'({ec, es}));
  endtask

  initial begin
    int n, nb, ndone;
    logic [8:0]  m;
    logic [7:0]  ra, rb;
    logic        rc;
    logic [2:0]  v;
    logic [1:0]  m1;

    tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    tbl[5] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    tbl[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[7] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};

    rst = 1'b1; start = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = 1'b0;
    b1 = 1'b0; cin1 = 1'b0;
    #2;
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst sum", 32'(sum), 0);
    chk("rst cout", 32'(cout), 0);
    chk("rst w1", 32'({busy1, done1, sum1, cout1}), 0);
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++)
      run8(tbl[i].a, tbl[i].b, tbl[i].cin,
           tbl[i].s, tbl[i].co, $sformatf("tbl%0d", i));

    // Random operands against plain integer addition.
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      m  = 9'(ra) + 9'(rb) + 9'(rc);
      run8(ra, rb, rc, m[7:0], m[8],
           $sformatf("rnd%0d", i));
    end

    // start re-pulsed during RUN must be ignored.
    start = 1'b1; a = 8'h3C; b = 8'h0F; cin = 1'b0;
    step();
    start = 1'b0;
    n = 0; nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      start = (n == 2 || n == 4);
      a = 8'hFF; b = 8'hFF; cin = 1'b1;
      step();
      n++;
    end
    start = 1'b0;
    chk("repulse latency", n, W);
    chk("repulse busylen", nb, W);
    chk("repulse sum", 32'(sum), 32'h4B);
    chk("repulse cout", 32'(cout), 0);
    step();
    chk("repulse idle", 32'({busy, done}), 0);

    // Back-to-back: start held in the DONE cycle.
    start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
    step();
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      step();
      n++;
    end
    chk("b2b first sum", 32'(sum), 32'h03);
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
    step();
    start = 1'b0;
    chk("b2b nogap busy", 32'(busy), 1);
    chk("b2b nogap done", 32'(done), 0);
    n = 0;
    while (!done && n < 40) begin
      step();
      n++;
    end
    chk("b2b latency", n, W);
    chk("b2b sum", 32'(sum), 32'h46);
    chk("b2b cout", 32'(cout), 0);
    step();

    // Reset during RUN cycle 4.
    start = 1'b1; a = 8'hFF; b = 8'h01; cin = 1'b0;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("midrst pre busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("midrst busy", 32'(busy), 0);
    chk("midrst done", 32'(done), 0);
    chk("midrst sum", 32'(sum), 0);
    chk("midrst cout", 32'(cout), 0);
    step();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) ndone++;
      step();
    end
    chk("midrst no done", ndone, 0);
    run8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "postrst");

    // WIDTH=1 build, every input combination.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      m1 = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      {a1, b1, cin1} = v;
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      {a1, b1, cin1} = ~v;
      chk($sformatf("w1 busy%0d", i), 32'(busy1), 1);
      n = 0;
      while (!done1 && n < 10) begin
        step();
        n++;
      end
      chk($sformatf("w1 latency%0d", i), n, 1);
      chk($sformatf("w1 res%0d", i),
          32'({cout1, sum1}), 32'(m1));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial N-bit adder controller that sequences a single instance of the team's 1-bit full adder cell. It processes one operand bit per clock, LSB first, and keeps the carry in a register between bits. A start/busy/done handshake presents the result as a parallel word plus carry-out. It sits beside the combinational adder cells as the area-minimal alternative for wide, non-latency-critical sums.

## Interface
- WIDTH, default 8: operand and sum width in bits; legal range WIDTH >= 1.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  WIDTH  operand A; sampled on the accepting edge only.
- b  in  WIDTH  operand B; sampled on the accepting edge only.
- cin  in  1  carry-in; sampled on the accepting edge only.
- busy  out  1  high while bits are being processed (RUN).
- done  out  1  single-cycle pulse; sum and cout are valid in that cycle.
- sum  out  WIDTH  result word; registered and held until the next done.
- cout  out  1  final carry; registered and held until the next done.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**:
  - start=1: latch a, b and cin into the A/B shift registers and the carry register; clear the bit counter; go to RUN.
  - Otherwise stay in IDLE.
- **RUN**, each cycle:
  - The full-adder cell sees A_sh[0], B_sh[0] and the carry register.
  - Cell sum shifts into the MSB of the result shift register, which shifts right.
  - A_sh and B_sh shift right.
  - The carry register takes the cell carry output.
  - The counter increments.
  - When the counter reaches WIDTH-1, the edge also copies the completed result into sum and the carry into cout, then goes to DONE.
  - start is ignored in RUN and is not queued.
- **DONE**, lasts one cycle:
  - done=1.
  - start=1: accept new operands exactly as IDLE does and go straight to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- Arithmetic: {cout,sum} = a + b + cin, exact modulo 2^(WIDTH+1), with no overflow flag.
- Counter width is $clog2(WIDTH)+1 bits. WIDTH=1 completes after a single RUN cycle.
- Input changes after acceptance have no effect on the operation in flight.

## Timing
- Reset values: IDLE; busy=0, done=0, sum=0, cout=0; all internal registers 0.
- Start accepted on edge E:
  - busy=1 for exactly WIDTH cycles, E+1 through E+WIDTH.
  - done=1 in the cycle after edge E+WIDTH.
  - sum and cout update on edge E+WIDTH.
- Latency from the accepting edge to the done pulse is WIDTH+1 edges.
- Maximum throughput is one result per WIDTH+1 cycles.
- busy and done are never high together.
- rst asserted mid-operation: immediate return to IDLE and all reset values. The in-flight result is discarded and no done pulse is issued.
- start coincident with rst release edge: ignored.

## Structure
- Shared package serial_adder_pkg holds:
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - a default-width constant.
- Sub-module: exactly one instance of the existing full_adder cell, ports a, b, cin, sum, carry. No other adder logic is permitted.
- Registers are all in the clk domain with asynchronous rst: state, counter, A_sh, B_sh, result shift register, carry register, sum, cout.

## Test plan
- WIDTH=8, a=0x0F, b=0x01, cin=0, start pulse:
  - busy high 8 cycles;
  - done at edge+9;
  - sum=0x10, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- start re-pulsed at cycles 3 and 5 of RUN with different operands -> ignored; the original result is delivered and busy length is unchanged.
- start held high during the done cycle with a=0x12, b=0x34 -> RUN resumes next cycle with no IDLE gap; second done gives sum=0x46, cout=0.
- rst pulsed during RUN cycle 4 -> busy, done, sum and cout are 0 immediately. No done pulse follows. A later start works normally.
- WIDTH=1 build, all 8 {a,b,cin} combinations -> each gives {cout,sum} equal to a+b+cin, with done two edges after acceptance.
